// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Shared RV32 decode constants for the decode stage and its register file.
//   XLEN / PC_W         : data width and PC width used across the pipeline
//   OPC_*               : the four opcodes the downstream ALU understands
//   F7_ALT, F3_SLL/SR   : funct fields that change how the immediate is formed
//   instr_class_e       : coarse instruction class derived from the opcode
//   classify()          : opcode -> instr_class_e
// ---------------------------------------------------------------------------
package rv_pkg;

  localparam int XLEN = 32;
  localparam int PC_W = 8;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_ALT = 7'b0100000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef enum logic [1:0] {
    CLS_R,
    CLS_I,
    CLS_U,
    CLS_ILL
  } instr_class_e;

  function automatic instr_class_e classify(input logic [6:0] opc);
    instr_class_e cls;
    case (opc)
      OPC_RTYPE:          cls = CLS_R;
      OPC_ITYPE:          cls = CLS_I;
      OPC_LUI, OPC_AUIPC: cls = CLS_U;
      default:            cls = CLS_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// ---------------------------------------------------------------------------
// regfile_2r1w
// 32 x XLEN register file, two combinational read ports, one write port.
// x0 always reads zero and ignores writes. A write presented in the same
// cycle as a read of the same (non-zero) index is forwarded to the read port.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset (clears all)
//   rs1_idx / rs1_data  : read port 1
//   rs2_idx / rs2_data  : read port 2
//   wb_en, wb_rd,
//   wb_data             : write port, committed on rising clk
// ---------------------------------------------------------------------------
module regfile_2r1w #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_idx,
  output logic [XLEN-1:0] rs1_data,
  input  logic [4:0]      rs2_idx,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] regs [32];

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en && (wb_rd != 5'd0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Same-cycle write data takes priority over the stored value.
  always_comb begin
    rs1_data = '0;
    if (rs1_idx != 5'd0) begin
      if (wb_en && (wb_rd == rs1_idx)) rs1_data = wb_data;
      else                             rs1_data = regs[rs1_idx];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_idx != 5'd0) begin
      if (wb_en && (wb_rd == rs2_idx)) rs2_data = wb_data;
      else                             rs2_data = regs[rs2_idx];
    end
  end

endmodule

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
// Decode / operand-fetch stage feeding the RV32 ALU. Accepts one instruction
// per cycle over valid/ready, decodes fields, reads the register file and
// registers the ALU operand bundle (latency 1 cycle).
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   if_valid/if_ready    : fetch handshake; if_instr, if_pc instruction + PC
//   ex_valid/ex_ready    : bundle handshake to ALU / writeback
//   ex_opcode..ex_pc     : decoded fields of the held bundle
//   ex_rs1_val/rs2_val   : operand values (kept current while held)
//   ex_rd, ex_wb_en      : destination and whether it is written
//   ex_illegal           : opcode outside the supported set
//   wb_en, wb_rd, wb_data: register file write port (ALU result)
// ---------------------------------------------------------------------------
module id_stage
  import rv_pkg::*;
#(
  parameter int XLEN = rv_pkg::XLEN,
  parameter int PC_W = rv_pkg::PC_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [PC_W-1:0] if_pc,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [6:0]      ex_opcode,
  output logic [6:0]      ex_funct7,
  output logic [2:0]      ex_funct3,
  output logic [11:0]     ex_imm,
  output logic [19:0]     ex_uimm,
  output logic [PC_W-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [4:0]      ex_rd,
  output logic            ex_wb_en,
  output logic            ex_illegal,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  logic [6:0]   f_opc;
  logic [4:0]   f_rd;
  logic [2:0]   f_f3;
  logic [4:0]   f_rs1;
  logic [4:0]   f_rs2;
  logic [6:0]   f_f7;
  instr_class_e cls;

  assign f_opc = if_instr[6:0];
  assign f_rd  = if_instr[11:7];
  assign f_f3  = if_instr[14:12];
  assign f_rs1 = if_instr[19:15];
  assign f_rs2 = if_instr[24:20];
  assign f_f7  = if_instr[31:25];
  assign cls   = classify(f_opc);

  logic [XLEN-1:0] rf_rs1;
  logic [XLEN-1:0] rf_rs2;

  regfile_2r1w #(.XLEN(XLEN)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1_idx  (f_rs1),
    .rs1_data (rf_rs1),
    .rs2_idx  (f_rs2),
    .rs2_data (rf_rs2),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data)
  );

  logic            d_use_rs1;
  logic            d_use_rs2;
  logic [6:0]      d_f7;
  logic [2:0]      d_f3;
  logic [11:0]     d_imm;
  logic [19:0]     d_uimm;
  logic [XLEN-1:0] d_rs1_val;
  logic [XLEN-1:0] d_rs2_val;
  logic            d_wb_en;
  logic            d_illegal;

  // Shift-immediates carry funct7 in the upper immediate bits, so the
  // immediate is only the 5-bit shamt in that case.
  always_comb begin
    d_use_rs1 = 1'b0;
    d_use_rs2 = 1'b0;
    d_f7      = '0;
    d_f3      = '0;
    d_imm     = '0;
    d_uimm    = '0;
    d_illegal = 1'b0;
    case (cls)
      CLS_R: begin
        d_use_rs1 = 1'b1;
        d_use_rs2 = 1'b1;
        d_f7      = f_f7;
        d_f3      = f_f3;
      end
      CLS_I: begin
        d_use_rs1 = 1'b1;
        d_f3      = f_f3;
        if ((f_f3 == F3_SLL) || (f_f3 == F3_SR)) begin
          d_f7  = f_f7;
          d_imm = {7'b0, if_instr[24:20]};
        end else begin
          d_imm = if_instr[31:20];
        end
      end
      CLS_U: begin
        d_use_rs1 = 1'b1;
        d_uimm    = if_instr[31:12];
      end
      default: begin
        d_illegal = 1'b1;
      end
    endcase
    d_wb_en   = !d_illegal && (f_rd != 5'd0);
    d_rs1_val = d_use_rs1 ? rf_rs1 : '0;
    d_rs2_val = d_use_rs2 ? rf_rs2 : '0;
  end

  logic load;
  assign if_ready = !ex_valid || ex_ready;
  assign load     = if_valid && if_ready;

  // Source indices of the held bundle, needed to keep its operands current
  // while the ALU stalls.
  logic [4:0] held_rs1;
  logic [4:0] held_rs2;
  logic       held_use_rs1;
  logic       held_use_rs2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_opcode    <= '0;
      ex_funct7    <= '0;
      ex_funct3    <= '0;
      ex_imm       <= '0;
      ex_uimm      <= '0;
      ex_pc        <= '0;
      ex_rs1_val   <= '0;
      ex_rs2_val   <= '0;
      ex_rd        <= '0;
      ex_wb_en     <= 1'b0;
      ex_illegal   <= 1'b0;
      held_rs1     <= '0;
      held_rs2     <= '0;
      held_use_rs1 <= 1'b0;
      held_use_rs2 <= 1'b0;
    end else if (load) begin
      ex_valid     <= 1'b1;
      ex_opcode    <= f_opc;
      ex_funct7    <= d_f7;
      ex_funct3    <= d_f3;
      ex_imm       <= d_imm;
      ex_uimm      <= d_uimm;
      ex_pc        <= if_pc;
      ex_rs1_val   <= d_rs1_val;
      ex_rs2_val   <= d_rs2_val;
      ex_rd        <= f_rd;
      ex_wb_en     <= d_wb_en;
      ex_illegal   <= d_illegal;
      held_rs1     <= f_rs1;
      held_rs2     <= f_rs2;
      held_use_rs1 <= d_use_rs1;
      held_use_rs2 <= d_use_rs2;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end else if (ex_valid && wb_en && (wb_rd != 5'd0)) begin
      // Stalled bundle: pick up writebacks to its sources so it never
      // issues with a stale operand.
      if (held_use_rs1 && (wb_rd == held_rs1)) ex_rs1_val <= wb_data;
      if (held_use_rs2 && (wb_rd == held_rs2)) ex_rs2_val <= wb_data;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage
// Scoreboard bench for id_stage. Accepted instructions are decoded by a
// reference model into an expected bundle queue; operand expectations come
// from an architectural register array, since a bundle's operands must
// always equal the current architectural value of its source registers.
// ---------------------------------------------------------------------------
module tb_id_stage;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [7:0]  if_pc;
  logic        ex_valid;
  logic        ex_ready;
  logic [6:0]  ex_opcode;
  logic [6:0]  ex_funct7;
  logic [2:0]  ex_funct3;
  logic [11:0] ex_imm;
  logic [19:0] ex_uimm;
  logic [7:0]  ex_pc;
  logic [31:0] ex_rs1_val;
  logic [31:0] ex_rs2_val;
  logic [4:0]  ex_rd;
  logic        ex_wb_en;
  logic        ex_illegal;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_opcode(ex_opcode), .ex_funct7(ex_funct7), .ex_funct3(ex_funct3),
    .ex_imm(ex_imm), .ex_uimm(ex_uimm), .ex_pc(ex_pc),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_rd(ex_rd), .ex_wb_en(ex_wb_en), .ex_illegal(ex_illegal),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  typedef struct packed {
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [11:0] imm;
    logic [19:0] uimm;
    logic [7:0]  pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use_rs1;
    logic        use_rs2;
    logic [4:0]  rd;
    logic        wb_en;
    logic        illegal;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] arch [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode, straight from the ISA field rules.
  function automatic exp_t modelDecode(input logic [31:0] ins, input logic [7:0] pc);
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    op = ins[6:0];
    f3 = ins[14:12];
    e = '0;
    e.opcode = op;
    e.pc     = pc;
    e.rd     = ins[11:7];
    e.rs1    = ins[19:15];
    e.rs2    = ins[24:20];
    if (op == OPC_RTYPE) begin
      e.funct7 = ins[31:25]; e.funct3 = f3; e.use_rs1 = 1; e.use_rs2 = 1;
    end else if (op == OPC_ITYPE) begin
      e.funct3 = f3; e.use_rs1 = 1;
      if (f3 == 3'b001 || f3 == 3'b101) begin
        e.funct7 = ins[31:25]; e.imm = {7'b0, ins[24:20]};
      end else begin
        e.imm = ins[31:20];
      end
    end else if (op == OPC_LUI || op == OPC_AUIPC) begin
      e.uimm = ins[31:12]; e.use_rs1 = 1;
    end else begin
      e.illegal = 1;
    end
    e.wb_en = !e.illegal && (e.rd != 0);
    return e;
  endfunction

  // Architectural state and scoreboard occupancy, advanced on each edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sb.delete();
      for (int i = 0; i < 32; i++) arch[i] = 32'h0;
    end else begin : adv
      bit was_valid;
      was_valid = (sb.size() > 0);
      if (was_valid && ex_ready) void'(sb.pop_front());
      if (if_valid && (!was_valid || ex_ready)) sb.push_back(modelDecode(if_instr, if_pc));
      if (wb_en && wb_rd != 5'd0) arch[wb_rd] = wb_data;
    end
  end

  // Monitor: compares the presented bundle with the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin : mon
      exp_t e;
      checkOutput("ex_valid", 32'(ex_valid), 32'(sb.size() > 0));
      checkOutput("if_ready", 32'(if_ready), 32'((sb.size() == 0) || ex_ready));
      if (sb.size() > 0 && ex_valid) begin
        e = sb[0];
        checkOutput("opcode",  32'(ex_opcode),  32'(e.opcode));
        checkOutput("funct7",  32'(ex_funct7),  32'(e.funct7));
        checkOutput("funct3",  32'(ex_funct3),  32'(e.funct3));
        checkOutput("imm",     32'(ex_imm),     32'(e.imm));
        checkOutput("uimm",    32'(ex_uimm),    32'(e.uimm));
        checkOutput("pc",      32'(ex_pc),      32'(e.pc));
        checkOutput("rd",      32'(ex_rd),      32'(e.rd));
        checkOutput("wb_en",   32'(ex_wb_en),   32'(e.wb_en));
        checkOutput("illegal", 32'(ex_illegal), 32'(e.illegal));
        checkOutput("rs1_val", ex_rs1_val, e.use_rs1 ? arch[e.rs1] : 32'h0);
        checkOutput("rs2_val", ex_rs2_val, e.use_rs2 ? arch[e.rs2] : 32'h0);
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [7:0] pc,
                               input logic rdy, input logic we, input logic [4:0] wrd,
                               input logic [31:0] wd);
    @(posedge clk);
    #1;
    if_valid = v; if_instr = ins; if_pc = pc; ex_ready = rdy;
    wb_en = we; wb_rd = wrd; wb_data = wd;
  endtask

  task automatic checkResetState();
    checkOutput("rst_valid",   32'(ex_valid),   32'h0);
    checkOutput("rst_opcode",  32'(ex_opcode),  32'h0);
    checkOutput("rst_funct7",  32'(ex_funct7),  32'h0);
    checkOutput("rst_funct3",  32'(ex_funct3),  32'h0);
    checkOutput("rst_imm",     32'(ex_imm),     32'h0);
    checkOutput("rst_uimm",    32'(ex_uimm),    32'h0);
    checkOutput("rst_pc",      32'(ex_pc),      32'h0);
    checkOutput("rst_rs1",     ex_rs1_val,      32'h0);
    checkOutput("rst_rs2",     ex_rs2_val,      32'h0);
    checkOutput("rst_rd",      32'(ex_rd),      32'h0);
    checkOutput("rst_wb_en",   32'(ex_wb_en),   32'h0);
    checkOutput("rst_illegal", 32'(ex_illegal), 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] ins;
    logic [6:0]  opc;
    rst = 1'b1; if_valid = 0; if_instr = 0; if_pc = 0; ex_ready = 0;
    wb_en = 0; wb_rd = 0; wb_data = 0;
    @(negedge clk);
    checkResetState();
    @(posedge clk); #1 rst = 1'b0;

    applyStimulus(0, 32'h0, 8'h00, 1, 1, 5'd1, 32'h10);
    applyStimulus(0, 32'h0, 8'h00, 1, 1, 5'd5, 32'h55);
    applyStimulus(1, 32'hFFF08113, 8'h04, 1, 0, 5'd0, 32'h0);   // ADDI x2,x1,-1
    applyStimulus(1, 32'h4040D193, 8'h08, 1, 0, 5'd0, 32'h0);   // SRAI x3,x1,4
    @(negedge clk);
    checkOutput("addi_rs1", ex_rs1_val, 32'h10);
    checkOutput("addi_imm", 32'(ex_imm), 32'hFFF);
    checkOutput("addi_rd",  32'(ex_rd), 32'd2);
    checkOutput("addi_wb",  32'(ex_wb_en), 32'd1);
    applyStimulus(1, 32'h00208233, 8'h0C, 1, 1, 5'd2, 32'h7);   // ADD x4,x1,x2 + wb x2=7
    @(negedge clk);
    checkOutput("srai_f7",  32'(ex_funct7), 32'(F7_ALT));
    checkOutput("srai_imm", 32'(ex_imm), 32'h004);
    checkOutput("srai_f3",  32'(ex_funct3), 32'h5);
    applyStimulus(1, 32'h00000333, 8'h10, 1, 1, 5'd0, 32'h5);   // ADD x6,x0,x0 + wb x0=5
    @(negedge clk);
    checkOutput("add_bypass", ex_rs2_val, 32'h7);
    applyStimulus(1, 32'h00140393, 8'h14, 1, 0, 5'd0, 32'h0);   // A: ADDI x7,x8,1
    @(negedge clk);
    checkOutput("x0_read", ex_rs1_val | ex_rs2_val, 32'h0);
    applyStimulus(1, 32'h00240493, 8'h18, 0, 0, 5'd0, 32'h0);   // B held back
    @(negedge clk);
    checkOutput("hold_ready", 32'(if_ready), 32'h0);
    applyStimulus(1, 32'h00240493, 8'h18, 0, 1, 5'd8, 32'h9);
    applyStimulus(1, 32'h00240493, 8'h18, 0, 0, 5'd0, 32'h0);
    @(negedge clk);
    checkOutput("hold_refresh", ex_rs1_val, 32'h9);
    checkOutput("hold_pc", 32'(ex_pc), 32'h14);
    applyStimulus(1, 32'h00240493, 8'h18, 1, 0, 5'd0, 32'h0);
    applyStimulus(1, 32'hABCDE2B7, 8'h1C, 1, 0, 5'd0, 32'h0);   // LUI x5,0xABCDE
    @(negedge clk);
    checkOutput("release_pc", 32'(ex_pc), 32'h18);
    applyStimulus(1, 32'h0000007F, 8'h20, 1, 0, 5'd0, 32'h0);   // illegal opcode
    @(negedge clk);
    checkOutput("lui_uimm", 32'(ex_uimm), 32'hABCDE);
    checkOutput("lui_imm",  32'(ex_imm), 32'h0);
    applyStimulus(0, 32'h0, 8'h00, 1, 0, 5'd0, 32'h0);
    @(negedge clk);
    checkOutput("ill_flag", 32'(ex_illegal), 32'h1);
    checkOutput("ill_wb",   32'(ex_wb_en), 32'h0);

    // Mid-stream reset with a stalled bundle.
    applyStimulus(1, 32'h00528333, 8'h24, 0, 0, 5'd0, 32'h0);   // ADD x6,x5,x5
    applyStimulus(0, 32'h0, 8'h00, 0, 0, 5'd0, 32'h0);
    #3 rst = 1'b1;
    #1 checkResetState();
    @(posedge clk); #1 rst = 1'b0;
    applyStimulus(1, 32'h00528333, 8'h28, 1, 0, 5'd0, 32'h0);
    applyStimulus(0, 32'h0, 8'h00, 1, 0, 5'd0, 32'h0);
    @(negedge clk);
    checkOutput("x5_after_rst", ex_rs1_val, 32'h0);

    for (int n = 0; n < 500; n++) begin
      case ($urandom_range(0, 5))
        0:       opc = OPC_RTYPE;
        1, 2:    opc = OPC_ITYPE;
        3:       opc = OPC_LUI;
        4:       opc = OPC_AUIPC;
        default: opc = 7'($urandom);
      endcase
      ins = $urandom;
      ins[6:0]   = opc;
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      applyStimulus(1'($urandom_range(0, 1)), ins, 8'($urandom),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), $urandom);
    end

    repeat (3) applyStimulus(0, 32'h0, 8'h00, 1, 0, 5'd0, 32'h0);
    @(negedge clk);
    checkOutput("drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
